// File: rtl/flex_sequencer.sv
// flex_sequencer: runs one flexcounter job per handshake, waiting for a requested number
// of terminal-count strobes, with abort and a sticky overrange error flag.
module flex_sequencer #(
   parameter int COUNTSIZE = 1024,
   parameter int REPW = 8,
   localparam int COUNTWIDTH = $clog2(COUNTSIZE)
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [COUNTWIDTH-1:0] req_period,
   input  logic [REPW-1:0]       req_repeat,
   input  logic                  abort,
   output logic                  enableCounter,
   output logic [COUNTWIDTH-1:0] maxCount,
   output logic                  cnt_nRST,
   input  logic                  strobe,
   input  logic [COUNTWIDTH-1:0] count,
   output logic                  tick,
   output logic                  done,
   output logic [REPW-1:0]       remaining,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic                  enable_counter_r;
   logic                  cnt_nrst_r;
   logic [COUNTWIDTH-1:0] max_count_r;
   logic [REPW-1:0]       remaining_r;
   logic                  err_r;
   logic                  req_ready_s;
   logic                  accept_s;
   logic                  job_ok_s;
   logic                  tick_s;
   logic                  done_s;
   logic                  cancel_s;

   // Next-state selection and the combinational handshake/pulse outputs.
   always_comb begin
      state_next_s = state_r;
      req_ready_s  = 1'b0;
      accept_s     = 1'b0;
      job_ok_s     = 1'b0;
      tick_s       = 1'b0;
      done_s       = 1'b0;
      cancel_s     = 1'b0;

      req_ready_s = (state_r == IDLE) && !RST;
      accept_s    = req_valid && req_ready_s;
      job_ok_s    = (req_period != {COUNTWIDTH{1'b0}}) && (req_repeat != {REPW{1'b0}});
      tick_s      = strobe && (state_r == RUN);
      done_s      = (state_r == DONE);
      cancel_s    = abort && ((state_r == RUN) || (state_r == CLEAR));

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (job_ok_s) begin
                  state_next_s = CLEAR;
               end else begin
                  state_next_s = DONE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         CLEAR: begin
            if (abort) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RUN;
            end
         end
         RUN: begin
            // Abort outranks a coincident final strobe.
            if (abort) begin
               state_next_s = IDLE;
            end else if (strobe && (remaining_r == REPW'(1))) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, counter-control registers and job bookkeeping.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_r          <= IDLE;
         enable_counter_r <= 1'b0;
         cnt_nrst_r       <= 1'b0;
         max_count_r      <= {COUNTWIDTH{1'b0}};
         remaining_r      <= {REPW{1'b0}};
         err_r            <= 1'b0;
      end else begin
         state_r          <= state_next_s;
         enable_counter_r <= (state_next_s == RUN);
         cnt_nrst_r       <= (state_next_s != CLEAR);

         if (accept_s) begin
            max_count_r <= req_period;
            remaining_r <= job_ok_s ? req_repeat : {REPW{1'b0}};
         end else if (cancel_s) begin
            remaining_r <= {REPW{1'b0}};
         end else if (tick_s) begin
            remaining_r <= remaining_r - REPW'(1);
         end else begin
            remaining_r <= remaining_r;
         end

         if (accept_s) begin
            err_r <= 1'b0;
         end else if ((state_r == RUN) && (count > max_count_r)) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign req_ready     = req_ready_s;
   assign enableCounter = enable_counter_r;
   assign cnt_nRST      = cnt_nrst_r;
   assign maxCount      = max_count_r;
   assign remaining     = remaining_r;
   assign err           = err_r;
   assign tick          = tick_s;
   assign done          = done_s;

endmodule

// File: tb/tb_flex_sequencer.sv
// Self-checking bench for flex_sequencer: a job-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_flex_sequencer;
   localparam int CW = 10;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          RST;
   logic          req_valid;
   logic          req_ready;
   logic [CW-1:0] req_period;
   logic [RW-1:0] req_repeat;
   logic          abort;
   logic          enableCounter;
   logic [CW-1:0] maxCount;
   logic          cnt_nRST;
   logic          strobe;
   logic [CW-1:0] count;
   logic          tick;
   logic          done;
   logic [RW-1:0] remaining;
   logic          err;

   logic          use_model;
   logic          drv_strobe;
   logic [CW-1:0] drv_count;
   logic [CW-1:0] tb_cnt = '0;
   logic          chk_en;

   int n_cmp = 0;
   int n_bad = 0;
   int n_tick = 0;
   int n_done = 0;

   flex_sequencer dut (
      .clk(clk), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_period(req_period), .req_repeat(req_repeat), .abort(abort),
      .enableCounter(enableCounter), .maxCount(maxCount), .cnt_nRST(cnt_nRST),
      .strobe(strobe), .count(count), .tick(tick), .done(done),
      .remaining(remaining), .err(err)
   );

   always #5 clk = ~clk;

   // Stand-in flexcounter: wraps at maxCount, strobing on the terminal value.
   assign strobe = use_model ? (enableCounter && (tb_cnt == maxCount)) : drv_strobe;
   assign count  = use_model ? tb_cnt : drv_count;

   always @(posedge clk) begin
      if (!cnt_nRST) tb_cnt <= '0;
      else if (enableCounter) tb_cnt <= (tb_cnt == maxCount) ? '0 : tb_cnt + 1'b1;
   end

   // Reference model: a job is "clearing", "counting" or "finishing"; none of these means idle.
   logic          m_clear, m_run, m_fin, m_rst_seen, m_err;
   logic [RW-1:0] m_left;
   logic [CW-1:0] m_max;
   wire           m_idle = !(m_clear || m_run || m_fin);

   always @(posedge clk) begin
      if (RST) begin
         m_clear <= 0; m_run <= 0; m_fin <= 0; m_rst_seen <= 1;
         m_left <= '0; m_max <= '0; m_err <= 0;
      end else begin
         m_rst_seen <= 0;
         if (m_idle) begin
            if (req_valid) begin
               m_max <= req_period;
               m_err <= 0;
               if (req_period != 0 && req_repeat != 0) begin
                  m_clear <= 1; m_left <= req_repeat;
               end else begin
                  m_fin <= 1; m_left <= '0;
               end
            end
         end else if (m_clear) begin
            m_clear <= 0;
            if (abort) m_left <= '0;
            else m_run <= 1;
         end else if (m_run) begin
            if (count > m_max) m_err <= 1;
            if (abort) begin
               m_run <= 0; m_left <= '0;
            end else if (strobe) begin
               m_left <= m_left - 1'b1;
               if (m_left == 1) begin
                  m_run <= 0; m_fin <= 1;
               end
            end
         end else begin
            m_fin <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(m_idle && !RST));
         chk("enableCounter", 32'(enableCounter), 32'(m_run));
         chk("cnt_nRST", 32'(cnt_nRST), 32'(!m_clear && !m_rst_seen));
         chk("maxCount", 32'(maxCount), 32'(m_max));
         chk("tick", 32'(tick), 32'(strobe && m_run));
         chk("done", 32'(done), 32'(m_fin));
         chk("remaining", 32'(remaining), 32'(m_left));
         chk("err", 32'(err), 32'(m_err));
         n_tick += int'(tick === 1'b1);
         n_done += int'(done === 1'b1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [CW-1:0] p, input logic [RW-1:0] r);
      step();
      req_valid = 1; req_period = p; req_repeat = r;
      step();
      req_valid = 0;
   endtask

   initial begin
      int k, lat, t0, d0;
      bit found;
      RST = 1; req_valid = 0; req_period = '0; req_repeat = '0; abort = 0;
      use_model = 1; drv_strobe = 0; drv_count = '0; chk_en = 0;

      // Reset values
      step(); chk_en = 1; step();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_cnt_nRST", 32'(cnt_nRST), 0);
      chk("rst_maxCount", 32'(maxCount), 0);
      step(); RST = 0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 1);
      step();
      @(negedge clk);
      chk("post_rst_cnt_nRST", 32'(cnt_nRST), 1);

      // period=3 repeat=2 with the counter stand-in
      start_job(10'd3, 8'd2);
      t0 = n_tick; k = 0; lat = 0; found = 0;
      while (!found && k < 40) begin
         k++;
         @(negedge clk);
         if (k == 1) begin
            chk("clear_cnt_nRST", 32'(cnt_nRST), 0);
            chk("clear_enable", 32'(enableCounter), 0);
            chk("clear_remaining", 32'(remaining), 2);
         end
         if (k == 2) chk("run_enable", 32'(enableCounter), 1);
         if (done === 1'b1) begin
            found = 1; lat = k;
            chk("done_enable_low", 32'(enableCounter), 0);
         end else begin
            step();
         end
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: got no done within 40 cycles, required done");
      end
      chk("done_latency", 32'(lat), 10);
      chk("tick_count", 32'(n_tick - t0), 2);
      step();
      @(negedge clk);
      chk("after_done_ready", 32'(req_ready), 1);
      chk("after_done_pulse", 32'(done), 0);

      // period=0 repeat=5: straight to DONE
      start_job(10'd0, 8'd5);
      @(negedge clk);
      chk("zero_done", 32'(done), 1);
      chk("zero_cnt_nRST", 32'(cnt_nRST), 1);
      chk("zero_enable", 32'(enableCounter), 0);
      step();
      @(negedge clk);
      chk("zero_done_once", 32'(done), 0);

      // Abort three cycles into RUN
      start_job(10'd7, 8'd4);
      step(); step(); step();
      abort = 1; d0 = n_done;
      @(negedge clk);
      chk("abort_pre_remaining", 32'(remaining), 4);
      step(); abort = 0;
      @(negedge clk);
      chk("abort_remaining", 32'(remaining), 0);
      chk("abort_ready", 32'(req_ready), 1);
      step(); step();
      @(negedge clk);
      chk("abort_no_done", 32'(n_done - d0), 0);

      // Abort together with the final strobe
      step(); use_model = 0;
      start_job(10'd5, 8'd1);
      step();
      drv_strobe = 1; abort = 1; d0 = n_done;
      @(negedge clk);
      chk("abort_strobe_tick", 32'(tick), 1);
      step(); drv_strobe = 0; abort = 0;
      @(negedge clk);
      chk("abort_strobe_ready", 32'(req_ready), 1);
      step(); step();
      @(negedge clk);
      chk("abort_strobe_no_done", 32'(n_done - d0), 0);

      // Overrange count sets sticky err
      start_job(10'd5, 8'd2);
      step();
      drv_count = 10'd6;
      step(); drv_count = '0; drv_strobe = 1;
      @(negedge clk);
      chk("err_set", 32'(err), 1);
      step();
      @(negedge clk);
      chk("err_remaining", 32'(remaining), 1);
      step(); drv_strobe = 0;
      @(negedge clk);
      chk("err_done", 32'(done), 1);
      chk("err_held_done", 32'(err), 1);
      step();
      @(negedge clk);
      chk("err_held_idle", 32'(err), 1);
      start_job(10'd2, 8'd1);
      @(negedge clk);
      chk("err_cleared", 32'(err), 0);
      step();

      // Busy request ignored, then reset mid-RUN with request held
      req_valid = 1; req_period = 10'd9; req_repeat = 8'd3; d0 = n_done;
      step();
      @(negedge clk);
      chk("busy_no_latch", 32'(maxCount), 2);
      chk("busy_ready", 32'(req_ready), 0);
      step(); RST = 1;
      step();
      @(negedge clk);
      chk("rst2_ready", 32'(req_ready), 0);
      chk("rst2_enable", 32'(enableCounter), 0);
      chk("rst2_cnt_nRST", 32'(cnt_nRST), 0);
      chk("rst2_maxCount", 32'(maxCount), 0);
      chk("rst2_remaining", 32'(remaining), 0);
      chk("rst2_err", 32'(err), 0);
      step(); RST = 0; req_valid = 0;
      @(negedge clk);
      chk("rst2_no_accept", 32'(maxCount), 0);
      step();
      @(negedge clk);
      chk("rst2_cnt_nRST_up", 32'(cnt_nRST), 1);
      chk("rst2_no_done", 32'(n_done - d0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/flex_sequencer.md
FLEX_SEQUENCER -- requirements
Module: flex_sequencer

Interface
REQ-001 The block SHALL have parameter COUNTSIZE, default 1024, meaning the counter range; derived localparam COUNTWIDTH = $clog2(COUNTSIZE).
REQ-002 The block SHALL have parameter REPW, default 8, meaning the width of the repeat count.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; ports are listed in REQ-004 to REQ-019.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 req_valid  input  1  job request.
REQ-007 req_ready  output  1  job accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 req_period  input  COUNTWIDTH  maxCount value for the job.
REQ-009 req_repeat  input  REPW  number of counter strobes to wait for.
REQ-010 abort  input  1  cancel the running job.
REQ-011 enableCounter  output  1  drives the flexcounter enable.
REQ-012 maxCount  output  COUNTWIDTH  drives the flexcounter terminal value.
REQ-013 cnt_nRST  output  1  active-low clear to the flexcounter.
REQ-014 strobe  input  1  flexcounter terminal-count pulse.
REQ-015 count  input  COUNTWIDTH  flexcounter current value.
REQ-016 tick  output  1  one-cycle pulse per strobe accepted in RUN.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 remaining  output  REPW  strobes still outstanding.
REQ-019 err  output  1  sticky protocol error flag.

Function
REQ-020 FSM states SHALL be exactly IDLE, CLEAR, RUN and DONE.
REQ-021 req_ready SHALL equal (state==IDLE) and not RST.
REQ-022 IDLE, on accept with req_period!=0 and req_repeat!=0: latch period into maxCount, load remaining=req_repeat, clear err, go to CLEAR.
REQ-023 IDLE, on accept with req_period==0 or req_repeat==0: latch period into maxCount, set remaining=0, clear err, go directly to DONE (no counting).
REQ-024 CLEAR SHALL last exactly one cycle, with cnt_nRST=0 and enableCounter=0, then go to RUN.
REQ-025 In RUN: enableCounter=1 and cnt_nRST=1; in all other states enableCounter=0; cnt_nRST=1 except in CLEAR and during RST.
REQ-026 enableCounter, cnt_nRST and maxCount SHALL be registered, with no combinational path from any input.
REQ-027 Latency: accept at edge N gives CLEAR during cycle N+1 and enableCounter=1 from cycle N+2.
REQ-028 tick SHALL be asserted (combinationally) exactly when strobe==1 and state==RUN; a strobe outside RUN is ignored.
REQ-029 In RUN, each strobe SHALL decrement remaining by 1; when strobe arrives with remaining==1, remaining goes to 0 and the state goes to DONE.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 abort in RUN or CLEAR: go to IDLE next edge, no done pulse, remaining cleared to 0.
REQ-032 abort in IDLE or DONE SHALL be ignored.
REQ-033 abort coincident with the final strobe: abort wins (tick still 1, no done).
REQ-034 err SHALL set when count > maxCount is sampled in RUN, hold until the next accept, and not alter sequencing.
REQ-035 maxCount SHALL hold its latched value until the next accept.
REQ-036 req_valid while not in IDLE SHALL be ignored (no accept, no latch).

Reset
REQ-037 While RST is high at an edge: state=IDLE, enableCounter=0, cnt_nRST=0, maxCount=0, remaining=0, done=0, err=0, req_ready=0.
REQ-038 The cycle after RST deasserts: req_ready=1, cnt_nRST=1.
REQ-039 RST mid-RUN SHALL discard the job with no done pulse.

Verification
REQ-040 Accept period=3, repeat=2, model counter strobing every 4 enabled cycles -> CLEAR 1 cycle, 2 ticks, remaining 2->1->0, done 1 cycle after the 2nd strobe, enableCounter low in DONE.
REQ-041 Accept period=0, repeat=5 -> DONE the next cycle, done pulse, no CLEAR, enableCounter never high.
REQ-042 Abort 3 cycles into RUN with repeat=4 -> IDLE next edge, remaining=0, no done, req_ready=1.
REQ-043 Abort and final strobe in the same cycle -> tick=1, done never asserted.
REQ-044 Inject count=maxCount+1 during RUN -> err=1 sticky through done, cleared on the next accept.
REQ-045 Assert RST mid-RUN, then req_valid during RUN and during RST -> reset values per REQ-037, no accept while busy or in reset.
